// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU sequencer: the op-code encoding and the FSM state encoding.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_XOR = 2'b00,
    ALU_NOR = 2'b01,
    ALU_OR  = 2'b10,
    ALU_AND = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'b00,
    SEQ_RUN  = 2'b01,
    SEQ_DONE = 2'b10
  } seq_state_e;

endpackage

// File: rtl/alu_serial_seq_shift_reg.sv
// serial_shift_reg: WIDTH-bit shift-right register.
// It has a parallel load, a shift enable and a serial input that enters at the MSB.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             sin_i,
  input  logic [WIDTH-1:0] par_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next value: a load takes priority over a shift.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = par_i;
    end else if (shift_i) begin
      q_d = (q_q >> 1) | (WIDTH'(sin_i) << (WIDTH - 1));
    end
  end

  // Storage register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial operand sequencer that drives a 1-bit ALU slice.
// Operands are streamed into the slice LSB-first, and the result bits are collected back into a word.
// Optional: define ALU_SERIAL_ZERO_FLAG_EN to add the o_zero result flag.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [1:0]       i_control,
  output logic             o_alu_a,
  output logic             o_alu_b,
  output logic [1:0]       o_alu_control,
  input  logic             i_alu_res,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_res,
  output logic             o_busy
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  ,
  output logic             o_zero
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  alu_op_e          ctl_q, ctl_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             load;
  logic             shift;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             unused_sh;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic             nz_q, nz_d;
`endif

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (load),
    .shift_i (shift),
    .sin_i   (1'b0),
    .par_i   (i_a),
    .q_o     (a_sh)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (load),
    .shift_i (shift),
    .sin_i   (1'b0),
    .par_i   (i_b),
    .q_o     (b_sh)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_res_sh (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .load_i  (load),
    .shift_i (shift),
    .sin_i   (i_alu_res),
    .par_i   ({WIDTH{1'b0}}),
    .q_o     (res_sh)
  );

  // Only bit 0 of each operand shifter feeds the slice. The other bits only carry data toward bit 0.
  assign unused_sh = ^{a_sh, b_sh};

  // Next-state logic: accept in IDLE, run WIDTH cycles of shifting, then hold the result in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctl_d   = ctl_q;
    load    = 1'b0;
    shift   = 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    nz_d    = nz_q;
`endif
    unique case (state_q)
      SEQ_IDLE: begin
        if (i_valid) begin
          load    = 1'b1;
          ctl_d   = alu_op_e'(i_control);
          cnt_d   = '0;
          state_d = SEQ_RUN;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
          nz_d    = 1'b0;
`endif
        end
      end
      SEQ_RUN: begin
        shift = 1'b1;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
        nz_d  = nz_q | i_alu_res;
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = SEQ_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEQ_DONE: begin
        if (i_ready) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
    ready_d = (state_d == SEQ_IDLE);
    busy_d  = (state_d == SEQ_RUN);
    valid_d = (state_d == SEQ_DONE);
  end

  // State, counter, latched op and status flags, with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
      ctl_q   <= ALU_XOR;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      nz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctl_q   <= ctl_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      nz_q    <= nz_d;
`endif
    end
  end

  assign o_ready       = ready_q;
  assign o_busy        = busy_q;
  assign o_valid       = valid_q;
  assign o_res         = res_sh;
  assign o_alu_control = ctl_q;
  assign o_alu_a       = busy_q & a_sh[0];
  assign o_alu_b       = busy_q & b_sh[0];
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  assign o_zero        = ~nz_q;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq.
// It instantiates one WIDTH=8 sequencer and one WIDTH=1 sequencer, each driving a 1-bit ALU slice model.
module tb_alu_serial_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // WIDTH=8 instance signals
  logic       v8, rdy8, ordy8, va8, busy8, alu_a8, alu_b8, alu_res8;
  logic [7:0] a8, b8, res8;
  logic [1:0] ctl8, alu_ctl8;
  // WIDTH=1 instance signals
  logic       v1, rdy1, ordy1, va1, busy1, alu_a1, alu_b1, alu_res1;
  logic [0:0] a1, b1, res1;
  logic [1:0] ctl1, alu_ctl1;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
  logic       zero8, zero1;
`endif

  function automatic logic slice(input logic a, input logic b, input logic [1:0] op);
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return ~(a | b);
      2'b10:   return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_res8 = slice(alu_a8, alu_b8, alu_ctl8);
  assign alu_res1 = slice(alu_a1, alu_b1, alu_ctl1);

  alu_serial_seq #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(ordy8),
    .i_a(a8), .i_b(b8), .i_control(ctl8),
    .o_alu_a(alu_a8), .o_alu_b(alu_b8), .o_alu_control(alu_ctl8), .i_alu_res(alu_res8),
    .o_valid(va8), .i_ready(rdy8), .o_res(res8), .o_busy(busy8)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    , .o_zero(zero8)
`endif
  );

  alu_serial_seq #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(ordy1),
    .i_a(a1), .i_b(b1), .i_control(ctl1),
    .o_alu_a(alu_a1), .o_alu_b(alu_b1), .o_alu_control(alu_ctl1), .i_alu_res(alu_res1),
    .o_valid(va1), .i_ready(rdy1), .o_res(res1), .o_busy(busy1)
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    , .o_zero(zero1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Accept one request on the WIDTH=8 instance and check latency, slice feed and result.
  // Returns with the instance in DONE and i_ready low.
  task automatic issue8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] exp);
    int n;
    chk({tag, "_ready_pre"}, 32'(ordy8), 32'd1);
    a8 = a; b8 = b; ctl8 = op; v8 = 1'b1; rdy8 = 1'b0;
    tick();
    v8 = 1'b0;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    chk({tag, "_ready_run"}, 32'(ordy8), 32'd0);
    chk({tag, "_alu_ab0"}, {30'd0, alu_a8, alu_b8}, {30'd0, a[0], b[0]});
    chk({tag, "_alu_ctl"}, 32'(alu_ctl8), 32'(op));
    n = 0;
    while (!va8 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd8);
    chk({tag, "_res"}, 32'(res8), 32'(exp));
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk({tag, "_zero"}, 32'(zero8), 32'(exp == 8'h00));
`endif
  endtask

  // Release a result held in DONE and check that the instance returns to IDLE.
  task automatic release8(input string tag);
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    chk({tag, "_valid_drop"}, 32'(va8), 32'd0);
    chk({tag, "_ready_back"}, 32'(ordy8), 32'd1);
  endtask

  initial begin
    int vseen;
    rst_n = 1'b0;
    v8 = 1'b0; rdy8 = 1'b0; a8 = '0; b8 = '0; ctl8 = '0;
    v1 = 1'b0; rdy1 = 1'b0; a1 = '0; b1 = '0; ctl1 = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", 32'(ordy8), 32'd1);
    chk("rst_valid", 32'(va8), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_res", 32'(res8), 32'd0);
    chk("rst_alu", {29'd0, alu_a8, alu_ctl8}, 32'd0);
    chk("rst_alu_b", 32'(alu_b8), 32'd0);

    // Test 1: XOR. The next slice bits are A5[1]=0 and 3C[1]=0.
    chk("t1_ready_pre", 32'(ordy8), 32'd1);
    a8 = 8'hA5; b8 = 8'h3C; ctl8 = 2'b00; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    chk("t1_alu_bit0", {30'd0, alu_a8, alu_b8}, 32'b10);
    tick();
    chk("t1_alu_bit1", {30'd0, alu_a8, alu_b8}, 32'b00);
    begin
      int n;
      n = 1;
      while (!va8 && n < 40) begin
        tick();
        n++;
      end
      chk("t1_latency", 32'(n), 32'd8);
    end
    chk("t1_res", 32'(res8), 32'h99);
    chk("t1_alu_idle", {30'd0, alu_a8, alu_b8}, 32'd0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk("t1_zero", 32'(zero8), 32'd0);
`endif
    release8("t1");

    // Test 2: NOR giving a zero result, then OR
    issue8("t2a", 8'hF0, 8'h0F, 2'b01, 8'h00);
    release8("t2a");
    issue8("t2b", 8'h12, 8'h40, 2'b10, 8'h52);
    release8("t2b");

    // Test 3: result held in DONE while a new request waits
    issue8("t3", 8'hFF, 8'h5A, 2'b11, 8'h5A);
    v8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid", 32'(va8), 32'd1);
      chk("t3_hold_res", 32'(res8), 32'h5A);
      chk("t3_hold_ready", 32'(ordy8), 32'd0);
    end
    rdy8 = 1'b1;
    tick();
    rdy8 = 1'b0;
    chk("t3_idle_valid", 32'(va8), 32'd0);
    chk("t3_idle_ready", 32'(ordy8), 32'd1);
    chk("t3_idle_busy", 32'(busy8), 32'd0);
    tick();
    v8 = 1'b0;
    chk("t3_next_busy", 32'(busy8), 32'd1);
    begin
      int n;
      n = 0;
      while (!va8 && n < 40) begin
        tick();
        n++;
      end
      chk("t3_next_latency", 32'(n), 32'd8);
    end
    chk("t3_next_res", 32'(res8), 32'h5A);
    release8("t3n");

    // Test 4: input changes after accept must not affect the op in flight
    chk("t4_ready_pre", 32'(ordy8), 32'd1);
    a8 = 8'h0F; b8 = 8'h01; ctl8 = 2'b11; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; ctl8 = 2'b00;
    tick();
    chk("t4_ctl_latched", 32'(alu_ctl8), 32'd3);
    begin
      int n;
      n = 1;
      while (!va8 && n < 40) begin
        tick();
        n++;
      end
      chk("t4_latency", 32'(n), 32'd8);
    end
    chk("t4_res", 32'(res8), 32'h01);
    release8("t4");

    // Test 5: reset asserted on the third RUN cycle aborts the op
    a8 = 8'hAA; b8 = 8'h0F; ctl8 = 2'b10; v8 = 1'b1;
    tick();
    v8 = 1'b0;
    tick();
    tick();
    chk("t5_busy_pre", 32'(busy8), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_busy", 32'(busy8), 32'd0);
    chk("t5_ready", 32'(ordy8), 32'd1);
    chk("t5_res", 32'(res8), 32'd0);
    chk("t5_ctl", 32'(alu_ctl8), 32'd0);
    vseen = 0;
    for (int i = 0; i < 12; i++) begin
      if (va8) vseen++;
      tick();
    end
    chk("t5_no_valid", 32'(vseen), 32'd0);

    // Test 6: WIDTH=1, 1 XOR 1
    chk("t6_ready_pre", 32'(ordy1), 32'd1);
    a1 = 1'b1; b1 = 1'b1; ctl1 = 2'b00; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    chk("t6_busy", 32'(busy1), 32'd1);
    chk("t6_valid_early", 32'(va1), 32'd0);
    tick();
    chk("t6_busy_off", 32'(busy1), 32'd0);
    chk("t6_valid", 32'(va1), 32'd1);
    chk("t6_res", 32'(res1), 32'd0);
`ifdef ALU_SERIAL_ZERO_FLAG_EN
    chk("t6_zero", 32'(zero1), 32'd1);
`endif
    rdy1 = 1'b1;
    tick();
    chk("t6_idle", {30'd0, ordy1, va1}, 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
